tx_frame_ctrl: RTL and testbench



---
 rtl/tx_frame_pkg.sv | 30 +++
 rtl/flex_counter_tick.sv | 49 ++++
 rtl/tx_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_tx_frame_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_pkg
//  Description : Shared types and constants for the transmit framing
//                controller: FSM state encoding, line-level start/stop
//                values and the frame-length helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_frame_pkg;

    // FSM states of the framing controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_e;

    // Line levels used when assembling a frame.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Total serial bits per frame: start + data + optional parity + stop(s).
    function automatic int calc_frame_bits(input int data_bits,
                                           input int parity_en,
                                           input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter_tick.sv
`default_nettype none
// ============================================================================
//  Module      : flex_counter_tick
//  Description : Rollover counter. Counts 0..rollover_i while en_i is high,
//                then wraps to 0. tick_o is high for the single enabled
//                cycle in which the count sits at rollover_i (the wrap
//                cycle). clear_i returns the count to 0.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en_i          - advance the count this cycle
//                clear_i       - force count to 0 on the next edge
//                rollover_i    - terminal count value
//                tick_o        - wrap indication (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_counter_tick #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] rollover_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tick_o = en_i && (count_q == rollover_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tick_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_ctrl
//  Description : Transmit framing controller feeding an LSB-first, idle-high
//                parallel-to-serial shifter. Accepts a word on a valid/ready
//                handshake, builds start/data/parity/stop frame, issues one
//                load strobe and then one shift strobe per bit period.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                data_in       - word to transmit (sampled at handshake only)
//                data_valid    - data_in valid
//                data_ready    - controller idle, can accept a word
//                parallel_out  - assembled frame to shifter parallel_in
//                load_enable   - one-cycle shifter load strobe
//                shift_enable  - one-cycle shifter shift strobe
//                busy          - frame in flight
//                frame_done    - pulse at the end of the final bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_ctrl
    import tx_frame_pkg::*;
#(
    parameter  int DATA_BITS    = 8,
    parameter  int CLKS_PER_BIT = 4,
    parameter  int PARITY_EN    = 0,
    parameter  int STOP_BITS    = 1,
    localparam int FRAME_BITS   = calc_frame_bits(DATA_BITS, PARITY_EN, STOP_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FRAME_BITS-1:0] parallel_out,
    output logic                  load_enable,
    output logic                  shift_enable,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(FRAME_BITS + 1);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [FRAME_BITS-1:0] frame_asm;
    logic                  baud_tick;
    logic                  bit_tick;
    logic                  cnt_clear;
    logic                  baud_en;

    // Frame assembly: everything defaults to stop level, then start bit,
    // payload and (optionally) even parity are overlaid from the LSB up.
    always_comb begin
        frame_asm              = {FRAME_BITS{STOP_BIT}};
        frame_asm[0]           = START_BIT;
        frame_asm[DATA_BITS:1] = data_in;
        if (PARITY_EN != 0) begin
            frame_asm[DATA_BITS+1] = ^data_in;
        end
    end

    // Both counters restart in the load cycle so the first bit period is a
    // full CLKS_PER_BIT cycles long.
    assign cnt_clear = (state_q == LOAD);
    assign baud_en   = (state_q == SEND);

    flex_counter_tick #(
        .WIDTH (BAUD_W)
    ) u_baud_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (baud_en),
        .clear_i    (cnt_clear),
        .rollover_i (BAUD_W'(CLKS_PER_BIT - 1)),
        .tick_o     (baud_tick)
    );

    // Bit counter advances once per bit period; its wrap marks the end of
    // the last bit period of the frame.
    flex_counter_tick #(
        .WIDTH (BIT_W)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .en_i       (baud_tick),
        .clear_i    (cnt_clear),
        .rollover_i (BIT_W'(FRAME_BITS - 1)),
        .tick_o     (bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        data_ready   = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        case (state_q)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    frame_d = frame_asm;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_enable = 1'b1;
                busy        = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                busy         = 1'b1;
                shift_enable = baud_tick;
                frame_done   = bit_tick;
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '1;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    assign parallel_out = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_frame_ctrl
//  Description : Directed self-checking bench for tx_frame_ctrl. Three
//                instances cover the base configuration, even parity, and
//                two stop bits with a short bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  d0, d1, d2;
    logic        v0, v1, v2;
    logic        rdy0, ld0, sh0, bz0, fd0;
    logic        rdy1, ld1, sh1, bz1, fd1;
    logic        rdy2, ld2, sh2, bz2, fd2;
    logic [9:0]  po0;
    logic [10:0] po1;
    logic [10:0] po2;

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(d0), .data_valid(v0), .data_ready(rdy0),
        .parallel_out(po0), .load_enable(ld0), .shift_enable(sh0), .busy(bz0), .frame_done(fd0));

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .data_valid(v1), .data_ready(rdy1),
        .parallel_out(po1), .load_enable(ld1), .shift_enable(sh1), .busy(bz1), .frame_done(fd1));

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(2), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(d2), .data_valid(v2), .data_ready(rdy2),
        .parallel_out(po2), .load_enable(ld2), .shift_enable(sh2), .busy(bz2), .frame_done(fd2));

    // Observation mux: the checks below look at whichever instance is selected.
    int          sel = 0;
    logic [31:0] o_po;
    logic        o_rdy, o_ld, o_sh, o_bz, o_fd;

    always_comb begin
        o_po = '0; o_rdy = 1'b0; o_ld = 1'b0; o_sh = 1'b0; o_bz = 1'b0; o_fd = 1'b0;
        case (sel)
            0: begin o_po = 32'(po0); o_rdy = rdy0; o_ld = ld0; o_sh = sh0; o_bz = bz0; o_fd = fd0; end
            1: begin o_po = 32'(po1); o_rdy = rdy1; o_ld = ld1; o_sh = sh1; o_bz = bz1; o_fd = fd1; end
            2: begin o_po = 32'(po2); o_rdy = rdy2; o_ld = ld2; o_sh = sh2; o_bz = bz2; o_fd = fd2; end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int s, input logic v, input logic [7:0] d);
        case (s)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d; end
            default: begin v2 = v; d2 = d; end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag, input int fb);
        check_eq({tag, "_ready"}, 32'(o_rdy), 32'd1);
        check_eq({tag, "_load"},  32'(o_ld),  32'd0);
        check_eq({tag, "_shift"}, 32'(o_sh),  32'd0);
        check_eq({tag, "_busy"},  32'(o_bz),  32'd0);
        check_eq({tag, "_done"},  32'(o_fd),  32'd0);
        check_eq({tag, "_po"},    o_po, 32'((64'd1 << fb) - 64'd1));
    endtask

    // mode 0: plain frame
    // mode 1: valid held high, second word nd follows immediately
    // mode 2: valid pulses and data toggles while busy
    // mode 3: reset asserted during the 3rd shift pulse
    task automatic run_frame(input int s, input logic [7:0] d, input int cpb, input int fb,
                             input logic [31:0] exp_po, input int mode,
                             input logic [7:0] nd, input logic [31:0] nexp);
        int          total;
        int          pulses;
        logic [31:0] sr;
        total  = fb * cpb;
        pulses = 0;
        sel    = s;
        #1;
        check_eq("idle_ready", 32'(o_rdy), 32'd1);
        set_in(s, 1'b1, d);
        step();
        // Load cycle L
        check_eq("load_strobe", 32'(o_ld), 32'd1);
        check_eq("load_shift",  32'(o_sh), 32'd0);
        check_eq("load_busy",   32'(o_bz), 32'd1);
        check_eq("load_ready",  32'(o_rdy), 32'd0);
        check_eq("load_po",     o_po, exp_po);
        sr = o_po;
        if (mode == 1) set_in(s, 1'b1, nd);
        else           set_in(s, 1'b0, d);
        for (int j = 1; j <= total; j++) begin
            step();
            check_eq("shift_timing", 32'(o_sh), 32'((j % cpb) == 0));
            check_eq("done_timing",  32'(o_fd), 32'(j == total));
            check_eq("send_load",    32'(o_ld), 32'd0);
            check_eq("send_busy",    32'(o_bz), 32'd1);
            check_eq("send_ready",   32'(o_rdy), 32'd0);
            check_eq("send_po",      o_po, exp_po);
            if (o_sh) begin
                // Shifter model: bit on the line during this period, then shift in idle-high.
                check_eq("line_bit", 32'(sr[0]), 32'(exp_po[pulses]));
                sr = {1'b1, sr[31:1]};
                pulses++;
            end
            if (mode == 2) begin
                set_in(s, ((j % 5) == 2) && (j < total - 1), 8'(j * 37));
            end
            if (mode == 3 && pulses == 3) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset_outputs("mid_rst", fb);
                for (int k = 0; k < 20; k++) begin
                    step();
                    check_eq("post_rst_load",  32'(o_ld), 32'd0);
                    check_eq("post_rst_shift", 32'(o_sh), 32'd0);
                end
                return;
            end
        end
        check_eq("pulse_count", 32'(pulses), 32'(fb));
        step();
        // L + total + 1
        check_eq("end_ready", 32'(o_rdy), 32'd1);
        check_eq("end_busy",  32'(o_bz),  32'd0);
        check_eq("end_shift", 32'(o_sh),  32'd0);
        check_eq("end_load",  32'(o_ld),  32'd0);
        check_eq("end_done",  32'(o_fd),  32'd0);
        if (mode == 1) begin
            step();
            check_eq("b2b_load", 32'(o_ld), 32'd1);
            check_eq("b2b_po",   o_po, nexp);
            set_in(s, 1'b0, nd);
            pulses = 0;
            for (int j = 1; j <= total; j++) begin
                step();
                if (o_sh) pulses++;
                check_eq("b2b_done", 32'(o_fd), 32'(j == total));
            end
            check_eq("b2b_pulses", 32'(pulses), 32'(fb));
            step();
            check_eq("b2b_ready", 32'(o_rdy), 32'd1);
            check_eq("b2b_hold",  o_po, nexp);
        end else begin
            check_eq("po_hold", o_po, exp_po);
            step();
            check_eq("no_stray_load", 32'(o_ld), 32'd0);
            check_eq("idle_hold",     32'(o_rdy), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
        rst = 1'b1;
        repeat (3) step();
        sel = 0; #1; check_reset_outputs("rst0", 10);
        sel = 1; #1; check_reset_outputs("rst1", 11);
        sel = 2; #1; check_reset_outputs("rst2", 11);
        // Reset dominates a simultaneous handshake.
        sel = 0;
        set_in(0, 1'b1, 8'hA5);
        step();
        check_reset_outputs("rst_hs", 10);
        set_in(0, 1'b0, 8'h00);
        rst = 1'b0;
        step();

        run_frame(0, 8'hA5, 4, 10, 32'h34A, 0, 8'h00, 32'h0);
        run_frame(1, 8'h07, 4, 11, 32'h60E, 0, 8'h00, 32'h0);
        run_frame(1, 8'h03, 4, 11, 32'h406, 0, 8'h00, 32'h0);
        run_frame(0, 8'h11, 4, 10, 32'h222, 1, 8'h22, 32'h244);
        run_frame(0, 8'h3C, 4, 10, 32'h278, 3, 8'h00, 32'h0);
        run_frame(0, 8'h5A, 4, 10, 32'h2B4, 2, 8'h00, 32'h0);
        run_frame(2, 8'h00, 2, 11, 32'h600, 0, 8'h00, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
